// File: rtl/imm_encoder.sv
// imm_encoder: inverse of the immediate extender. Searches for a 24-bit
// instruction immediate field that expands back to the given 32-bit value.
// Optional feature macro: ROT_IMM_EN (enables the 16-step rotate search for
// imm_src 00; when undefined only rotate 0 is tried).
module imm_encoder (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [31:0] value,
    input  logic [1:0]  imm_src,
    output logic        busy,
    output logic        done,
    output logic        valid,
    output logic [23:0] imm_field
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SEARCH = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_next;

    logic [31:0] r_value;
    logic [1:0]  r_src;
    logic [3:0]  r_rot;
    logic        r_valid;
    logic [23:0] r_imm;

    logic [31:0] w_cand;
    logic        w_last_rot;
    logic        w_finish;
    logic        w_res_valid;
    logic [23:0] w_res_imm;
    logic        w_accept;

`ifdef ROT_IMM_EN
    logic [63:0] w_dbl;

    // Rotate-left by 2*rot: the upper half of the doubled word shifted left
    assign w_dbl      = {r_value, r_value} << {r_rot, 1'b0};
    assign w_cand     = w_dbl[63:32];
    assign w_last_rot = (r_rot == 4'd15);
`else
    assign w_cand     = r_value;
    assign w_last_rot = 1'b1;
`endif

    // A new request is taken whenever no search is running
    assign w_accept = start && (r_state != ST_SEARCH);

    // Evaluate the current candidate and decide whether the search ends now
    always_comb begin
        w_res_valid = 1'b0;
        w_res_imm   = '0;
        w_finish    = 1'b1;
        case (r_src)
            2'b00: begin
                if (w_cand[31:8] == '0) begin
                    w_res_valid = 1'b1;
                    w_res_imm   = {12'b0, r_rot, w_cand[7:0]};
                end else begin
                    w_finish = w_last_rot;
                end
            end
            2'b01: begin
                if (r_value[31:12] == '0) begin
                    w_res_valid = 1'b1;
                    w_res_imm   = {12'b0, r_value[11:0]};
                end
            end
            2'b10: begin
                if ((r_value[1:0] == 2'b00) &&
                    (r_value[31:25] == {7{r_value[25]}})) begin
                    w_res_valid = 1'b1;
                    w_res_imm   = r_value[25:2];
                end
            end
            default: begin
                w_res_valid = 1'b0;
                w_res_imm   = '0;
            end
        endcase
    end

    // Next-state logic for IDLE / SEARCH / DONE
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:   if (start) w_next = ST_SEARCH;
            ST_SEARCH: if (w_finish) w_next = ST_DONE;
            ST_DONE:   w_next = start ? ST_SEARCH : ST_IDLE;
            default:   w_next = ST_IDLE;
        endcase
    end

    // State register, request latch, rotate counter and result registers
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
            r_value <= '0;
            r_src   <= '0;
            r_rot   <= '0;
            r_valid <= 1'b0;
            r_imm   <= '0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_value <= value;
                r_src   <= imm_src;
                r_rot   <= '0;
            end else if (r_state == ST_SEARCH) begin
                if (w_finish) begin
                    r_valid <= w_res_valid;
                    r_imm   <= w_res_imm;
                end else begin
                    r_rot <= r_rot + 4'd1;
                end
            end
        end
    end

    assign busy      = (r_state == ST_SEARCH);
    assign done      = (r_state == ST_DONE);
    assign valid     = r_valid;
    assign imm_field = r_imm;

endmodule
